vec_exec_unit: RTL and testbench
================================

# vec_exec_unit

Multi-cycle vector execution stage that sits directly downstream of the 8-entry × 256-bit vector register file. It consumes the two read-port operands, performs a lane-wise or reducing operation on 16 lanes of 16-bit integers, and drives the register file write port (`wr_en`, `wr_dst`, `wr_data`) for exactly one cycle per accepted operation. Iterative operations share a small multiplier bank, and the unit exposes a start/busy handshake to the issue logic.

## Interface
- `LANES`, 16, number of lanes per vector.
- `LANE_W`, 16, bits per lane. `LANES*LANE_W` must equal 256.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: issue request; sampled only when `busy`=0.
- `op` in 3: operation code; see Operation.
- `dst` in 3: destination vector register index.
- `src_a` in 256: operand A (register file `data_1`).
- `src_b` in 256: operand B (register file `data_2`).
- `busy` out 1: unit occupied; `start` is ignored while high.
- `wr_en` out 1: one-cycle write strobe to the register file.
- `wr_dst` out 3: write destination; valid only while `wr_en`=1.
- `wr_data` out 256: write data; valid only while `wr_en`=1.
- `illegal` out 1: one-cycle pulse when a reserved op completes.

## Operation
- Lane i occupies bits `[16i+15:16i]`. All arithmetic is modulo 2^16, with no saturation and no flags.
- Op codes:
  - 0 VADD: `a+b` per lane.
  - 1 VSUB: `a−b` per lane.
  - 2 VAND: `a&b` per lane.
  - 3 VMUL: low 16 bits of `a*b` per lane.
  - 4 VDOT: Σ `a_i*b_i` (low 16 bits of each product, 16-bit wrapping sum) written to lane 0; lanes 1–15 are written as 0.
  - 5–7: reserved.
- On an accepted `start`, the unit captures `op`, `dst`, `src_a` and `src_b` into internal registers. Later changes on the inputs have no effect.
- FSM states: IDLE, RUN, WB.
  - IDLE→WB when `start` is accepted with op 0–2 or op 5–7.
  - IDLE→RUN when `start` is accepted with op 3 or op 4.
  - RUN iterates a 4-bit counter `idx`.
    - VMUL processes lanes 4k..4k+3 per cycle, for k=0..3, taking 4 cycles.
    - VDOT accumulates one lane per cycle, for idx=0..15, taking 16 cycles.
    - RUN→WB after the last iteration.
  - WB→IDLE unconditionally after one cycle.
- In WB:
  - op 0–4: `wr_en`=1, with `wr_dst`=captured `dst`.
  - op 5–7: `wr_en`=0, `illegal`=1, and no register write occurs.
- A `start` in the WB cycle is ignored (`busy`=1). The earliest re-issue is the cycle after WB.

## Timing
- Reset values: `busy`=0, `wr_en`=0, `illegal`=0, `wr_dst`=0, `wr_data`=0. State is IDLE, `idx`=0, and the accumulator is 0.
- Latency, with `start` sampled at edge N:
  - op 0–2 and reserved ops: `wr_en` (or `illegal`) high in cycle N+1.
  - VMUL: strobe in N+5.
  - VDOT: strobe in N+17.
- `busy` is high from cycle N+1 through the WB cycle inclusive, and low in the cycle following WB.
- `wr_en`, `wr_dst` and `wr_data` are registered outputs. `wr_data` holds its last value outside WB; consumers must qualify it with `wr_en`.
- Reset in any state returns to IDLE on the next edge. It discards the in-flight result, and no `wr_en` pulse follows.
- `start` held continuously issues one operation per completion; each issue re-samples the inputs at that edge.

## Structure
- Shared package `vec_pkg`, containing:
  - `LANES`, `LANE_W`, and `VEC_W`=256.
  - `REG_IDX_W`=3.
  - op enum `vec_op_t` (VADD, VSUB, VAND, VMUL, VDOT).
  - FSM state enum.
  - function `lane(v,i)` returning the 16-bit slice.
- Sub-module `vec_mul4`: four parallel 16×16 multipliers with 16-bit truncated outputs, combinational. It is shared by VMUL (all 4 products) and VDOT (product 0 only).
- The top module holds the FSM, `idx` counter, operand/result registers, and accumulator.

## Test plan
- VADD: lanes a=0xFFFF, b=0x0002 in all lanes, dst=5 → one `wr_en` pulse at N+1, `wr_dst`=5, every lane 0x0001, `busy` high for 1 cycle.
- VMUL: a lane i = i+1, b lane i = 0x1000 → `wr_en` at N+5; lane i = (i+1)·0x1000 mod 2^16 (lane 15 = 0x0000); `start` asserted at N+2 is ignored.
- VDOT: a=b=0x0003 in all lanes → `wr_en` at N+17, lane 0 = 0x0090, lanes 1–15 = 0.
- Reserved op 6 → `illegal` pulse at N+1, no `wr_en`; unit re-accepts VSUB at N+2 and writes 5−7=0xFFFE per lane at N+3.
- `rst` asserted at N+8 during VDOT → IDLE next edge, no `wr_en` at N+17, all outputs at reset values.
- Back-to-back VAND with `start` held high and inputs changing every cycle → strobes every 2 cycles, each using the inputs sampled at its own issue edge.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types, sizes and lane helpers for the vector execution stage.
package vec_pkg;

    localparam int LANES     = 16;
    localparam int LANE_W    = 16;
    localparam int VEC_W     = LANES * LANE_W;
    localparam int REG_IDX_W = 3;
    localparam int MUL_N     = 4;

    typedef logic [3:0] lane_idx_t;

    typedef enum logic [2:0] {
        VADD = 3'd0,
        VSUB = 3'd1,
        VAND = 3'd2,
        VMUL = 3'd3,
        VDOT = 3'd4
    } vec_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB
    } vec_state_t;

    function automatic logic [LANE_W-1:0] lane(input logic [VEC_W-1:0] v, input lane_idx_t i);
        return v[i*LANE_W +: LANE_W];
    endfunction

    function automatic logic is_iterative(input logic [2:0] o);
        return (o == VMUL) || (o == VDOT);
    endfunction

    function automatic logic is_lanewise(input logic [2:0] o);
        return (o == VADD) || (o == VSUB) || (o == VAND);
    endfunction

endpackage

// File: rtl/vec_mul4.sv
// Four parallel 16x16 multipliers truncated to 16 bits, shared by VMUL and VDOT.
module vec_mul4
    import vec_pkg::*;
(
    input  logic [LANE_W-1:0] a [MUL_N],
    input  logic [LANE_W-1:0] b [MUL_N],
    output logic [LANE_W-1:0] p [MUL_N]
);

    always_comb begin
        for (int j = 0; j < MUL_N; j++) begin
            p[j] = LANE_W'(a[j] * b[j]);
        end
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution stage: lane-wise ALU ops finish in one cycle,
// VMUL/VDOT iterate over the shared multiplier bank before a single write-back.
module vec_exec_unit
    import vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [REG_IDX_W-1:0] dst,
    input  logic [VEC_W-1:0]     src_a,
    input  logic [VEC_W-1:0]     src_b,
    output logic                 busy,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_dst,
    output logic [VEC_W-1:0]     wr_data,
    output logic                 illegal
);

    vec_state_t           state;
    lane_idx_t            idx;
    logic [2:0]           op_q;
    logic [REG_IDX_W-1:0] dst_q;
    logic [VEC_W-1:0]     a_q;
    logic [VEC_W-1:0]     b_q;
    logic [VEC_W-1:0]     res_q;
    logic [LANE_W-1:0]    acc;

    logic [LANE_W-1:0]    mul_a [MUL_N];
    logic [LANE_W-1:0]    mul_b [MUL_N];
    logic [LANE_W-1:0]    mul_p [MUL_N];
    logic [VEC_W-1:0]     simple_res;
    logic [VEC_W-1:0]     mul_res;
    logic [LANE_W-1:0]    acc_next;
    logic                 last_iter;

    // VMUL feeds lanes 4k..4k+3 into all four multipliers; VDOT only uses product 0 on lane idx.
    always_comb begin
        for (int j = 0; j < MUL_N; j++) begin
            mul_a[j] = lane(a_q, (op_q == VDOT) ? idx : {idx[1:0], 2'(j)});
            mul_b[j] = lane(b_q, (op_q == VDOT) ? idx : {idx[1:0], 2'(j)});
        end
    end

    vec_mul4 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        mul_res = res_q;
        for (int j = 0; j < MUL_N; j++) begin
            mul_res[{idx[1:0], 2'(j)} * LANE_W +: LANE_W] = mul_p[j];
        end
    end

    assign acc_next  = acc + mul_p[0];
    assign last_iter = (op_q == VMUL) ? (idx == 4'd3) : (idx == 4'd15);

    // Single-cycle ops are evaluated straight from the ports at the issue edge.
    always_comb begin
        simple_res = '0;
        for (int i = 0; i < LANES; i++) begin
            case (op)
                VADD:    simple_res[i*LANE_W +: LANE_W] = lane(src_a, lane_idx_t'(i)) + lane(src_b, lane_idx_t'(i));
                VSUB:    simple_res[i*LANE_W +: LANE_W] = lane(src_a, lane_idx_t'(i)) - lane(src_b, lane_idx_t'(i));
                VAND:    simple_res[i*LANE_W +: LANE_W] = lane(src_a, lane_idx_t'(i)) & lane(src_b, lane_idx_t'(i));
                default: simple_res[i*LANE_W +: LANE_W] = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            acc     <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            illegal <= 1'b0;
            wr_dst  <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        dst_q <= dst;
                        a_q   <= src_a;
                        b_q   <= src_b;
                        idx   <= '0;
                        acc   <= '0;
                        res_q <= '0;
                        busy  <= 1'b1;
                        if (is_iterative(op)) begin
                            state <= S_RUN;
                        end else begin
                            state <= S_WB;
                            if (is_lanewise(op)) begin
                                wr_en   <= 1'b1;
                                wr_dst  <= dst;
                                wr_data <= simple_res;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    idx   <= idx + 4'd1;
                    res_q <= mul_res;
                    acc   <= acc_next;
                    // The last iteration's products go straight into the write-back registers.
                    if (last_iter) begin
                        state   <= S_WB;
                        wr_en   <= 1'b1;
                        wr_dst  <= dst_q;
                        wr_data <= (op_q == VMUL) ? mul_res : {{(VEC_W-LANE_W){1'b0}}, acc_next};
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit: timeline model plus directed vectors.
module tb_vec_exec_unit;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [2:0]   dst;
    logic [255:0] src_a;
    logic [255:0] src_b;
    logic         busy;
    logic         wr_en;
    logic [2:0]   wr_dst;
    logic [255:0] wr_data;
    logic         illegal;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int cycle_now;
    int issue_edge = 0;
    int strobe_count = 0;
    logic checking = 1'b0;

    logic         pend_valid = 1'b0;
    int           pend_due = 0;
    logic         pend_illegal = 1'b0;
    logic [2:0]   pend_dst = '0;
    logic [255:0] pend_data = '0;
    logic         exp_strobe;

    vec_exec_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .dst     (dst),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_dst  (wr_dst),
        .wr_data (wr_data),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] model_result(input logic [2:0] o, input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        int unsigned x, y, s;
        r = '0;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            x = a[16*i +: 16];
            y = b[16*i +: 16];
            case (o)
                3'd0: r[16*i +: 16] = 16'(x + y);
                3'd1: r[16*i +: 16] = 16'(x - y);
                3'd2: r[16*i +: 16] = 16'(x & y);
                3'd3: r[16*i +: 16] = 16'(x * y);
                3'd4: s = s + 16'(x * y);
                default: ;
            endcase
        end
        if (o == 3'd4) r[15:0] = 16'(s);
        return r;
    endfunction

    function automatic int model_latency(input logic [2:0] o);
        if (o == 3'd3) return 5;
        if (o == 3'd4) return 17;
        return 1;
    endfunction

    function automatic logic [255:0] splat(input logic [15:0] v);
        return {16{v}};
    endfunction

    task automatic check_output(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Timeline model: one operation in flight, due at issue edge + latency.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend_valid = 1'b0;
            checking   = 1'b1;
        end else begin
            if (pend_valid && cyc > pend_due) pend_valid = 1'b0;
            if (!pend_valid && start) begin
                pend_valid   = 1'b1;
                pend_due     = cyc + model_latency(op);
                pend_illegal = (op > 3'd4);
                pend_dst     = dst;
                pend_data    = model_result(op, src_a, src_b);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            cycle_now  = cyc + 1;
            exp_strobe = pend_valid && (cycle_now == pend_due);
            check_output("busy", 256'(busy), 256'(pend_valid && cycle_now <= pend_due));
            check_output("wr_en", 256'(wr_en), 256'(exp_strobe && !pend_illegal));
            check_output("illegal", 256'(illegal), 256'(exp_strobe && pend_illegal));
            if (exp_strobe && !pend_illegal) begin
                check_output("wr_dst", 256'(wr_dst), 256'(pend_dst));
                check_output("wr_data", wr_data, pend_data);
            end
            if (wr_en) strobe_count++;
        end
    end

    task automatic apply_stimulus(input logic [2:0] o, input logic [2:0] d, input logic [255:0] a, input logic [255:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        dst   = d;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start      = 1'b0;
        issue_edge = cyc;
    endtask

    task automatic wait_strobe(input int max_cycles, output int latency);
        latency = -1;
        for (int k = 0; k < max_cycles; k++) begin
            if (wr_en || illegal) begin
                latency = cyc + 1 - issue_edge;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int strobes_before;
        logic [255:0] ramp;

        rst = 1'b1;
        start = 1'b0;
        op = '0;
        dst = '0;
        src_a = '0;
        src_b = '0;
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        check_output("rst_busy", 256'(busy), 256'(0));
        check_output("rst_wr_en", 256'(wr_en), 256'(0));
        check_output("rst_illegal", 256'(illegal), 256'(0));
        check_output("rst_wr_dst", 256'(wr_dst), 256'(0));
        check_output("rst_wr_data", wr_data, 256'(0));
        rst = 1'b0;

        $display("[TB] VADD wrap");
        apply_stimulus(3'd0, 3'd5, splat(16'hFFFF), splat(16'h0002));
        wait_strobe(4, lat);
        check_output("vadd_latency", 256'(lat), 256'(1));
        check_output("vadd_dst", 256'(wr_dst), 256'(5));
        check_output("vadd_data", wr_data, splat(16'h0001));
        @(negedge clk);
        check_output("vadd_busy_after", 256'(busy), 256'(0));

        $display("[TB] VMUL ramp");
        for (int i = 0; i < 16; i++) ramp[16*i +: 16] = 16'(i + 1);
        apply_stimulus(3'd3, 3'd1, ramp, splat(16'h1000));
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        dst   = 3'd7;
        @(negedge clk);
        start = 1'b0;
        wait_strobe(10, lat);
        check_output("vmul_latency", 256'(lat), 256'(5));
        check_output("vmul_dst", 256'(wr_dst), 256'(1));
        check_output("vmul_data", wr_data,
                     256'h0000F000E000D000C000B000A000900080007000600050004000300020001000);
        repeat (3) @(negedge clk);

        $display("[TB] VDOT");
        apply_stimulus(3'd4, 3'd3, splat(16'h0003), splat(16'h0003));
        wait_strobe(25, lat);
        check_output("vdot_latency", 256'(lat), 256'(17));
        check_output("vdot_data", wr_data, 256'h90);
        repeat (2) @(negedge clk);

        $display("[TB] reserved op then VSUB");
        apply_stimulus(3'd6, 3'd4, splat(16'h1234), splat(16'h4321));
        check_output("rsv_illegal", 256'(illegal), 256'(1));
        check_output("rsv_wr_en", 256'(wr_en), 256'(0));
        apply_stimulus(3'd1, 3'd2, splat(16'h0005), splat(16'h0007));
        wait_strobe(4, lat);
        check_output("vsub_latency", 256'(lat), 256'(1));
        check_output("vsub_data", wr_data, splat(16'hFFFE));
        repeat (2) @(negedge clk);

        $display("[TB] reset during VDOT");
        apply_stimulus(3'd4, 3'd6, splat(16'h0011), splat(16'h0022));
        for (int k = 0; k < 20 && cyc < issue_edge + 7; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_busy", 256'(busy), 256'(0));
        check_output("abort_wr_en", 256'(wr_en), 256'(0));
        check_output("abort_wr_dst", 256'(wr_dst), 256'(0));
        check_output("abort_wr_data", wr_data, 256'(0));
        strobes_before = strobe_count;
        repeat (12) @(negedge clk);
        check_output("abort_no_strobe", 256'(strobe_count - strobes_before), 256'(0));

        $display("[TB] back-to-back VAND");
        strobes_before = strobe_count;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b1;
            op    = 3'd2;
            dst   = 3'(k);
            src_a = {8{$urandom()}};
            src_b = {8{$urandom()}};
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("b2b_strobes", 256'(strobe_count - strobes_before), 256'(4));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
